event_counter_bank: RTL and testbench

Parametrised multi-channel event counter, successor to the single 16-bit trigger counter. Each channel counts trigger events, level- or edge-qualified, in a configurable direction. Channels wrap or saturate at the range limits and flag boundary crossings. A shared capture strobe snapshots all channels at once for coherent readout through a select mux. The block sits between event sources (buttons, comparators, protocol strobes) and the readout/display logic.

---
 rtl/event_counter_bank.sv | 109 ++++++++++
 tb/tb_event_counter_bank.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/event_counter_bank.sv
// Multi-channel trigger event counter with wrap/saturate limits, sticky boundary flags
// and a shared capture strobe that snapshots every channel into a readout shadow bank.
module event_counter_bank #(
    parameter int WIDTH     = 16,
    parameter int CHANNELS  = 4,
    parameter int SATURATE  = 0,
    parameter int EDGE_MODE = 1,
    localparam int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       trigger,
    input  logic [CHANNELS-1:0]       clear,
    input  logic                      down,
    input  logic                      load,
    input  logic [SELW-1:0]           load_sel,
    input  logic [WIDTH-1:0]          load_value,
    input  logic                      capture,
    input  logic [SELW-1:0]           read_sel,
    output logic [WIDTH-1:0]          read_count,
    output logic [CHANNELS*WIDTH-1:0] live_count,
    output logic [CHANNELS-1:0]       overflow,
    output logic [CHANNELS-1:0]       tc
);

    localparam logic [WIDTH-1:0] MAXV = '1;

    logic [CHANNELS-1:0] trig_q;
    logic [CHANNELS-1:0] ovf_q, ovf_d;
    logic [CHANNELS-1:0] tc_q, tc_d;
    logic [CHANNELS-1:0] evt;
    logic [WIDTH-1:0]    cnt_q    [CHANNELS];
    logic [WIDTH-1:0]    cnt_d    [CHANNELS];
    logic [WIDTH-1:0]    shadow_q [CHANNELS];

    assign evt = (EDGE_MODE != 0) ? (trigger & ~trig_q) : trigger;

    // Per-channel priority: clear, then load, then a qualified event, else hold.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = cnt_q[i];
            ovf_d[i] = ovf_q[i];
            tc_d[i]  = 1'b0;
            if (clear[i]) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (load && (load_sel == SELW'(i))) begin
                cnt_d[i] = load_value;
                ovf_d[i] = 1'b0;
            end else if (evt[i]) begin
                if (!down) begin
                    if (cnt_q[i] == MAXV) begin
                        cnt_d[i] = (SATURATE != 0) ? MAXV : '0;
                        ovf_d[i] = 1'b1;
                        tc_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end else begin
                    if (cnt_q[i] == '0) begin
                        cnt_d[i] = (SATURATE != 0) ? '0 : MAXV;
                        ovf_d[i] = 1'b1;
                        tc_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] - 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            trig_q <= '0;
            ovf_q  <= '0;
            tc_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]    <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            trig_q <= trigger;
            ovf_q  <= ovf_d;
            tc_q   <= tc_d;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
                // Shadow takes the pre-update value so a capture is coherent across channels.
                if (capture) shadow_q[i] <= cnt_q[i];
            end
        end
    end

    always_comb begin
        read_count = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (read_sel == SELW'(i)) read_count = shadow_q[i];
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            live_count[i*WIDTH +: WIDTH] = cnt_q[i];
        end
    end

    assign overflow = ovf_q;
    assign tc       = tc_q;

endmodule

// File: tb/tb_event_counter_bank.sv
// Directed bench for event_counter_bank: four instances (wrap/edge, saturate, level, 3-channel)
// share one stimulus stream; each phase checks the instance it exercises.
module tb_event_counter_bank;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  trigger, clear;
    logic        down, load, capture;
    logic [1:0]  load_sel, read_sel;
    logic [15:0] load_value;

    logic [15:0] rd_a, rd_s, rd_l, rd_c;
    logic [63:0] live_a, live_s, live_l;
    logic [47:0] live_c;
    logic [3:0]  ovf_a, ovf_s, ovf_l, tc_a, tc_s, tc_l;
    logic [2:0]  ovf_c, tc_c;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    event_counter_bank #(.WIDTH(16), .CHANNELS(4), .SATURATE(0), .EDGE_MODE(1)) dut_a (
        .clock(clock), .reset(reset), .trigger(trigger), .clear(clear), .down(down),
        .load(load), .load_sel(load_sel), .load_value(load_value), .capture(capture),
        .read_sel(read_sel), .read_count(rd_a), .live_count(live_a), .overflow(ovf_a), .tc(tc_a));

    event_counter_bank #(.WIDTH(16), .CHANNELS(4), .SATURATE(1), .EDGE_MODE(1)) dut_s (
        .clock(clock), .reset(reset), .trigger(trigger), .clear(clear), .down(down),
        .load(load), .load_sel(load_sel), .load_value(load_value), .capture(capture),
        .read_sel(read_sel), .read_count(rd_s), .live_count(live_s), .overflow(ovf_s), .tc(tc_s));

    event_counter_bank #(.WIDTH(16), .CHANNELS(4), .SATURATE(0), .EDGE_MODE(0)) dut_l (
        .clock(clock), .reset(reset), .trigger(trigger), .clear(clear), .down(down),
        .load(load), .load_sel(load_sel), .load_value(load_value), .capture(capture),
        .read_sel(read_sel), .read_count(rd_l), .live_count(live_l), .overflow(ovf_l), .tc(tc_l));

    event_counter_bank #(.WIDTH(16), .CHANNELS(3), .SATURATE(0), .EDGE_MODE(1)) dut_c (
        .clock(clock), .reset(reset), .trigger(trigger[2:0]), .clear(clear[2:0]), .down(down),
        .load(load), .load_sel(load_sel), .load_value(load_value), .capture(capture),
        .read_sel(read_sel), .read_count(rd_c), .live_count(live_c), .overflow(ovf_c), .tc(tc_c));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; trigger = '0; clear = '0; down = 1'b0; load = 1'b0;
        load_sel = '0; load_value = '0; capture = 1'b0; read_sel = '0;
        tick(); tick();
        chk("reset_live", live_a, 64'h0);
        chk("reset_read", {48'h0, rd_a}, 64'h0);
        chk("reset_ovf_tc", {56'h0, ovf_a, tc_a}, 64'h0);

        // Trigger already high on the first edge after release: counts once.
        reset = 1'b0; trigger = 4'b0001;
        for (int k = 0; k < 10; k++) tick();
        chk("hold_edge_ch0", live_a[15:0], 16'd1);
        chk("hold_level_ch0", live_l[15:0], 16'd10);
        trigger = '0; tick();
        for (int k = 0; k < 5; k++) begin
            trigger = 4'b0001; tick();
            trigger = 4'b0000; tick();
        end
        chk("pulse_edge_ch0", live_a[15:0], 16'd6);
        chk("pulse_level_ch0", live_l[15:0], 16'd15);
        chk("pulse_c_ch0", live_c[15:0], 16'd6);
        capture = 1'b1; tick(); capture = 1'b0;
        chk("first_capture", rd_a, 16'd6);

        // Asynchronous reset between edges clears everything without waiting for the clock.
        trigger = 4'b0001; tick();
        chk("pre_reset_ch0", live_a[15:0], 16'd7);
        #2 reset = 1'b1;
        #1;
        chk("async_live", live_a, 64'h0);
        chk("async_read", rd_a, 16'h0);
        trigger = '0; tick(); reset = 1'b0;

        // Wrap: ch1 from 0xFFFE up through the limit, then down through zero.
        load = 1'b1; load_sel = 2'd1; load_value = 16'hFFFE; tick(); load = 1'b0;
        chk("load_ch1", live_a[31:16], 16'hFFFE);
        trigger = 4'b0010; tick();
        chk("wrap_up1", live_a[31:16], 16'hFFFF);
        chk("wrap_up1_tc", tc_a, 4'b0000);
        trigger = '0; tick();
        trigger = 4'b0010; tick();
        chk("wrap_up2", live_a[31:16], 16'h0000);
        chk("wrap_up2_tc", tc_a, 4'b0010);
        chk("wrap_up2_ovf", ovf_a, 4'b0010);
        trigger = '0; tick();
        chk("wrap_tc_drop", tc_a, 4'b0000);
        chk("wrap_ovf_sticky", ovf_a, 4'b0010);
        trigger = 4'b0010; tick();
        chk("wrap_up3", live_a[31:16], 16'h0001);
        trigger = '0; tick();
        down = 1'b1;
        trigger = 4'b0010; tick();
        chk("wrap_dn1", live_a[31:16], 16'h0000);
        chk("wrap_dn1_tc", tc_a, 4'b0000);
        trigger = '0; tick();
        trigger = 4'b0010; tick();
        chk("wrap_dn2", live_a[31:16], 16'hFFFF);
        chk("wrap_dn2_tc", tc_a, 4'b0010);
        trigger = '0; tick();
        down = 1'b0;

        // Saturate: ch2 held at 0xFFFF, a tc pulse per event; the wrap instance runs 0,1,2,3.
        load = 1'b1; load_sel = 2'd2; load_value = 16'hFFFF; tick(); load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            trigger = 4'b0100; tick();
            chk("sat_hold", live_s[47:32], 16'hFFFF);
            chk("sat_tc", {63'h0, tc_s[2]}, 64'h1);
            trigger = '0; tick();
            chk("sat_tc_gap", {63'h0, tc_s[2]}, 64'h0);
        end
        chk("sat_ovf", {63'h0, ovf_s[2]}, 64'h1);
        chk("wrap_ch2", live_a[47:32], 16'd3);
        clear = 4'b0100; tick(); clear = '0;
        chk("sat_clear", live_s[47:32], 16'h0);
        chk("sat_clear_ovf", {63'h0, ovf_s[2]}, 64'h0);

        // Priority on ch3: clear beats load and event; load drops a coincident event.
        load = 1'b1; load_sel = 2'd3; load_value = 16'd5; tick();
        chk("pri_setup", live_a[63:48], 16'd5);
        clear = 4'b1000; load_value = 16'h1234; trigger = 4'b1000; tick();
        chk("pri_clear", live_a[63:48], 16'h0);
        clear = '0; load = 1'b0; trigger = '0; tick();
        load = 1'b1; trigger = 4'b1000; tick(); load = 1'b0;
        chk("pri_load", live_a[63:48], 16'h1234);
        tick();
        chk("pri_held_trig", live_a[63:48], 16'h1234);
        trigger = '0; tick();
        trigger = 4'b1000; tick(); trigger = '0;
        chk("pri_count", live_a[63:48], 16'h1235);
        chk("c_ignores_sel3", {16'h0, live_c}, {16'h0, 16'h0, 16'hFFFF, 16'h0});
        load = 1'b1; load_sel = 2'd1; load_value = 16'd7; tick(); load = 1'b0;
        chk("load_clears_ovf", ovf_a, 4'b0000);
        chk("load_ch1_7", live_a[31:16], 16'd7);

        // Capture coherency: all channels count on alternate cycles.
        tick();
        for (int k = 0; k < 3; k++) begin
            trigger = 4'b1111; tick();
            trigger = 4'b0000; tick();
        end
        trigger = 4'b1111; capture = 1'b1; tick();
        trigger = '0; capture = 1'b0;
        chk("cap_live", live_a, {16'h1239, 16'd4, 16'd11, 16'd4});
        read_sel = 2'd0; #1 chk("cap_a0", rd_a, 16'd3);  chk("cap_c0", rd_c, 16'd3);
        read_sel = 2'd1; #1 chk("cap_a1", rd_a, 16'd10); chk("cap_c1", rd_c, 16'd10);
        read_sel = 2'd2; #1 chk("cap_a2", rd_a, 16'd3);  chk("cap_c2", rd_c, 16'd3);
        read_sel = 2'd3; #1 chk("cap_a3", rd_a, 16'h1238); chk("cap_c_oob", rd_c, 16'h0);
        tick();
        trigger = 4'b1111; tick(); trigger = '0;
        chk("cap_stable", rd_a, 16'h1238);

        // Level mode: seven high cycles on ch0 count seven.
        clear = 4'b1111; tick(); clear = '0;
        trigger = 4'b0001;
        for (int k = 0; k < 7; k++) tick();
        trigger = '0; tick();
        chk("level_7", live_l[15:0], 16'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
